// File: rtl/cdr_pkg.sv
// Shared types and constants for the CDR transmit serializer.
package cdr_pkg;

  typedef enum logic [1:0] {OFF, TRAIN, RUN} tx_state_t;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_IDLE = 2'b10;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  // Training frames and the plain idle payload are MSB-aligned slices of this.
  localparam logic [63:0] ALT_PATTERN = {32{2'b10}};

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7+x^6+1) source; bit_o is the register MSB and advances only when step is high.
module prbs7_gen
  import cdr_pkg::*;
(
  input  logic refclk,
  input  logic rst,
  input  logic step,
  output logic bit_o
);

  logic [6:0] lfsr;

  always_ff @(posedge refclk) begin
    if (rst) lfsr <= PRBS7_SEED;
    else if (step) lfsr <= {lfsr[5:0], ^(lfsr & PRBS7_TAPS)};
  end

  assign bit_o = lfsr[6];

endmodule

// File: rtl/cdr_tx_serializer.sv
// Framed serial source for the CDR receive path: training preamble, then header+payload frames.
// Build option CDR_TX_PRBS_IDLE_EN: idle payload comes from a PRBS7 generator instead of 1010...
module cdr_tx_serializer
  import cdr_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TRAIN_FRAMES = 16
)
(
  input  logic             refclk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d,
  output logic             frame_start,
  output logic             busy,
  output logic [15:0]      tx_count
);

  localparam int FRAME_LEN = WIDTH + 2;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int TW = (TRAIN_FRAMES > 1) ? $clog2(TRAIN_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TRAIN = TW'(TRAIN_FRAMES - 1);
  localparam logic [FRAME_LEN-1:0] TRAIN_FRAME = ALT_PATTERN[63 -: FRAME_LEN];
  localparam logic [WIDTH-1:0] IDLE_PAYLOAD = ALT_PATTERN[63 -: WIDTH];

  tx_state_t            state, state_nx;
  logic [CW-1:0]        bit_cnt;
  logic [TW-1:0]        train_cnt;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] frame_nx;
  logic                 idle_frame, idle_nx;
  logic                 boundary, accept;
  logic                 payload_bit;

  // The next frame is chosen only at a boundary; in_ready opens only when that frame is RUN.
  always_comb begin
    boundary = (state == OFF) || (bit_cnt == LAST_BIT);
    state_nx = state;
    in_ready = 1'b0;
    frame_nx = TRAIN_FRAME;
    idle_nx  = 1'b0;
    if (boundary) begin
      unique case (state)
        OFF: if (en) state_nx = TRAIN;
        TRAIN: begin
          if (!en) state_nx = OFF;
          else if (train_cnt == LAST_TRAIN) begin
            state_nx = RUN;
            in_ready = !rst;
          end
        end
        RUN: begin
          if (!en) state_nx = OFF;
          else in_ready = !rst;
        end
        default: state_nx = OFF;
      endcase
    end
    accept = in_valid && in_ready;
    if (state_nx == RUN) begin
      if (accept) frame_nx = {HDR_DATA, in_data};
      else begin
        frame_nx = {HDR_IDLE, IDLE_PAYLOAD};
        idle_nx  = 1'b1;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) state <= OFF;
    else state <= state_nx;
  end

  // d always presents the bit indexed by bit_cnt; a boundary loads the next frame's first bit.
  always_ff @(posedge refclk) begin
    if (rst) begin
      bit_cnt     <= '0;
      train_cnt   <= '0;
      shreg       <= '0;
      idle_frame  <= 1'b0;
      d           <= 1'b0;
      frame_start <= 1'b0;
      tx_count    <= '0;
    end else begin
      if (accept) tx_count <= tx_count + 16'd1;
      if (boundary) begin
        bit_cnt    <= '0;
        idle_frame <= idle_nx;
        if (state_nx == OFF) begin
          d           <= 1'b0;
          frame_start <= 1'b0;
          shreg       <= '0;
        end else begin
          d           <= frame_nx[FRAME_LEN-1];
          frame_start <= 1'b1;
          shreg       <= {frame_nx[FRAME_LEN-2:0], 1'b0};
        end
        if (state == OFF) train_cnt <= '0;
        else if (state == TRAIN && state_nx == TRAIN) train_cnt <= train_cnt + 1'b1;
      end else begin
        bit_cnt     <= bit_cnt + 1'b1;
        d           <= payload_bit;
        frame_start <= 1'b0;
        shreg       <= {shreg[FRAME_LEN-2:0], 1'b0};
      end
    end
  end

`ifdef CDR_TX_PRBS_IDLE_EN
  logic prbs_step, prbs_bit;

  // Payload bits of an idle frame are fetched in bit_cnt 1..FRAME_LEN-2, one PRBS step each.
  assign prbs_step = idle_frame && !boundary && (bit_cnt != '0);

  prbs7_gen u_prbs (
    .refclk (refclk),
    .rst    (rst),
    .step   (prbs_step),
    .bit_o  (prbs_bit)
  );

  assign payload_bit = prbs_step ? prbs_bit : shreg[FRAME_LEN-1];
`else
  assign payload_bit = shreg[FRAME_LEN-1];
`endif

  assign busy = (state != OFF);

endmodule
